// File: rtl/prime_failover_ctrl.sv
// Dual-channel prime selector with debounced health, power-on-reset retries
// and per-channel lockout after repeated failures.
module prime_failover_ctrl #(
    parameter int unsigned STARTUP_TIMEOUT = 250000000,
    parameter int unsigned POR_CYCLES      = 50000000,
    parameter int unsigned STABLE_CYCLES   = 16,
    parameter int unsigned MAX_RETRIES     = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] health,
    input  logic       manual_swap,
    input  logic       clear_lockout,
    output logic [1:0] prime,
    output logic [1:0] por,
    output logic [1:0] lockout,
    output logic [1:0] retry_cnt0,
    output logic [1:0] retry_cnt1
);

    localparam int STW = $clog2(STARTUP_TIMEOUT + 1);
    localparam int PW  = $clog2(POR_CYCLES + 1);
    localparam int FW  = $clog2(STABLE_CYCLES + 1);

    localparam logic [STW-1:0] START_MAX = STW'(STARTUP_TIMEOUT);
    localparam logic [PW-1:0]  POR_LAST  = PW'(POR_CYCLES - 1);
    localparam logic [FW-1:0]  FILT_LAST = FW'(STABLE_CYCLES - 1);
    localparam logic [1:0]     RETRY_MAX = 2'(MAX_RETRIES);

    // The enum values double as the prime output encoding.
    typedef enum logic [1:0] {
        NO_PRIME = 2'b00,
        PRIME_A  = 2'b01,
        PRIME_B  = 2'b10
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             fh_q, fhDly_q;
    logic [1:0][FW-1:0]     filtCnt_q;
    logic [STW-1:0]         startCnt_q;
    logic [1:0]             por_q, por_d;
    logic [1:0][PW-1:0]     porCnt_q, porCnt_d;
    logic [1:0]             lockout_q, lockout_d;
    logic [1:0][1:0]        retry_q, retry_d;
    logic [1:0][1:0]        retryBase;
    logic [1:0]             eligible;
    logic [1:0]             fail;
    logic                   toReached;

    assign toReached    = (startCnt_q == START_MAX);
    assign eligible     = fh_q & ~por_q & ~lockout_q;
    assign fail         = fhDly_q & ~fh_q & ~por_q & ~lockout_q;
    assign retryBase[0] = clear_lockout ? 2'b00 : retry_q[0];
    assign retryBase[1] = clear_lockout ? 2'b00 : retry_q[1];

    // Debounce raw health: fh follows health only after a sustained disagreement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fh_q      <= '0;
            fhDly_q   <= '0;
            filtCnt_q <= '0;
        end else begin
            fhDly_q <= fh_q;
            for (int i = 0; i < 2; i++) begin
                if (health[i] != fh_q[i]) begin
                    if (filtCnt_q[i] == FILT_LAST) begin
                        fh_q[i]      <= health[i];
                        filtCnt_q[i] <= '0;
                    end else begin
                        filtCnt_q[i] <= filtCnt_q[i] + 1'b1;
                    end
                end else begin
                    filtCnt_q[i] <= '0;
                end
            end
        end
    end

    // Startup counter saturates so channel B can eventually claim prime on its own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            startCnt_q <= '0;
        end else if (!toReached) begin
            startCnt_q <= startCnt_q + 1'b1;
        end
    end

    // Per-channel restart bookkeeping: por pulse timing, retry counts, lockout.
    always_comb begin
        por_d     = por_q;
        porCnt_d  = porCnt_q;
        lockout_d = lockout_q;
        retry_d   = retry_q;
        for (int i = 0; i < 2; i++) begin
            retry_d[i] = retryBase[i];
            if (clear_lockout) begin
                lockout_d[i] = 1'b0;
            end
            if (por_q[i]) begin
                if (porCnt_q[i] == '0) begin
                    por_d[i] = 1'b0;
                end else begin
                    porCnt_d[i] = porCnt_q[i] - 1'b1;
                end
            end
            if (fail[i]) begin
                if (retryBase[i] < RETRY_MAX) begin
                    por_d[i]    = 1'b1;
                    porCnt_d[i] = POR_LAST;
                    retry_d[i]  = retryBase[i] + 2'd1;
                end else begin
                    lockout_d[i] = 1'b1;
                end
            end
        end
    end

    // Register the restart bookkeeping; reset aborts any pulse in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            por_q     <= '0;
            porCnt_q  <= '0;
            lockout_q <= '0;
            retry_q   <= '0;
        end else begin
            por_q     <= por_d;
            porCnt_q  <= porCnt_d;
            lockout_q <= lockout_d;
            retry_q   <= retry_d;
        end
    end

    // Prime selection: A preferred from idle, failover on ineligibility, manual swap.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NO_PRIME: begin
                if (eligible[0]) begin
                    state_d = PRIME_A;
                end else if (toReached && eligible[1]) begin
                    state_d = PRIME_B;
                end
            end
            PRIME_A: begin
                if (!eligible[0]) begin
                    state_d = eligible[1] ? PRIME_B : NO_PRIME;
                end else if (manual_swap && eligible[1]) begin
                    state_d = PRIME_B;
                end
            end
            PRIME_B: begin
                if (!eligible[1]) begin
                    state_d = eligible[0] ? PRIME_A : NO_PRIME;
                end else if (manual_swap && eligible[0]) begin
                    state_d = PRIME_A;
                end
            end
            default: state_d = NO_PRIME;
        endcase
    end

    // Prime state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= NO_PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    assign prime      = state_q;
    assign por        = por_q;
    assign lockout    = lockout_q;
    assign retry_cnt0 = retry_q[0];
    assign retry_cnt1 = retry_q[1];

endmodule

// File: tb/tb_prime_failover_ctrl.sv
// Directed and randomized checks of prime_failover_ctrl against a behavioural model.
module tb_prime_failover_ctrl;

    localparam int TO     = 100;
    localparam int PORC   = 20;
    localparam int STABLE = 4;
    localparam int MAXR   = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] health = 2'b00;
    logic       manual_swap = 1'b0;
    logic       clear_lockout = 1'b0;
    logic [1:0] prime, por, lockout, retry_cnt0, retry_cnt1;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Behavioural model: channel index of prime (-1 none), remaining pulse
    // cycles, debounce run lengths, plain integer counters.
    int mPrime;
    int mStart;
    int mFh[2];
    int mFhOld[2];
    int mRun[2];
    int mPorLeft[2];
    int mLock[2];
    int mRetry[2];

    prime_failover_ctrl #(
        .STARTUP_TIMEOUT(TO),
        .POR_CYCLES(PORC),
        .STABLE_CYCLES(STABLE),
        .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .health(health),
        .manual_swap(manual_swap),
        .clear_lockout(clear_lockout),
        .prime(prime),
        .por(por),
        .lockout(lockout),
        .retry_cnt0(retry_cnt0),
        .retry_cnt1(retry_cnt1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d: observed %b expected %b", tag, cycle, observed, expected);
        end
    endtask

    task automatic modelReset();
        mPrime = -1;
        mStart = 0;
        for (int i = 0; i < 2; i++) begin
            mFh[i] = 0; mFhOld[i] = 0; mRun[i] = 0;
            mPorLeft[i] = 0; mLock[i] = 0; mRetry[i] = 0;
        end
    endtask

    task automatic modelStep(input logic [1:0] h, input logic sw, input logic clr);
        int elig[2];
        int failed[2];
        int nPrime;
        int other;
        int base;
        for (int i = 0; i < 2; i++) begin
            elig[i]   = (mFh[i] == 1 && mPorLeft[i] == 0 && mLock[i] == 0) ? 1 : 0;
            failed[i] = (mFhOld[i] == 1 && mFh[i] == 0 && mPorLeft[i] == 0 && mLock[i] == 0) ? 1 : 0;
        end
        if (mPrime < 0) begin
            if (elig[0] == 1) nPrime = 0;
            else if (mStart >= TO && elig[1] == 1) nPrime = 1;
            else nPrime = -1;
        end else begin
            other = 1 - mPrime;
            if (elig[mPrime] == 0) nPrime = (elig[other] == 1) ? other : -1;
            else if (sw && elig[other] == 1) nPrime = other;
            else nPrime = mPrime;
        end
        for (int i = 0; i < 2; i++) begin
            base = clr ? 0 : mRetry[i];
            if (clr) mLock[i] = 0;
            if (mPorLeft[i] > 0) mPorLeft[i]--;
            mRetry[i] = base;
            if (failed[i] == 1) begin
                if (base < MAXR) begin
                    mPorLeft[i] = PORC;
                    mRetry[i]   = base + 1;
                end else begin
                    mLock[i] = 1;
                end
            end
            mFhOld[i] = mFh[i];
            if (int'(h[i]) != mFh[i]) begin
                mRun[i]++;
                if (mRun[i] == STABLE) begin
                    mFh[i]  = int'(h[i]);
                    mRun[i] = 0;
                end
            end else begin
                mRun[i] = 0;
            end
        end
        mStart = (mStart + 1 > TO) ? TO : mStart + 1;
        mPrime = nPrime;
    endtask

    task automatic compareModel();
        logic [1:0] ePrime;
        ePrime = (mPrime < 0) ? 2'b00 : ((mPrime == 0) ? 2'b01 : 2'b10);
        checkOutput("prime", prime, ePrime);
        checkOutput("por", por, {mPorLeft[1] > 0, mPorLeft[0] > 0});
        checkOutput("lockout", lockout, {mLock[1] == 1, mLock[0] == 1});
        checkOutput("retry_cnt0", retry_cnt0, 2'(mRetry[0]));
        checkOutput("retry_cnt1", retry_cnt1, 2'(mRetry[1]));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after.
    task automatic applyStimulus(input logic [1:0] h, input logic sw, input logic clr);
        health        = h;
        manual_swap   = sw;
        clear_lockout = clr;
        @(posedge clk);
        modelStep(h, sw, clr);
        cycle++;
        #1;
        compareModel();
    endtask

    task automatic repeatStimulus(input logic [1:0] h, input int n);
        for (int k = 0; k < n; k++) applyStimulus(h, 1'b0, 1'b0);
    endtask

    // Assert reset asynchronously, check the cleared outputs, release after an edge.
    task automatic doReset();
        reset_n = 1'b0;
        manual_swap = 1'b0;
        clear_lockout = 1'b0;
        #2;
        checkOutput("rst_prime", prime, 2'b00);
        checkOutput("rst_por", por, 2'b00);
        checkOutput("rst_lockout", lockout, 2'b00);
        checkOutput("rst_retry0", retry_cnt0, 2'b00);
        checkOutput("rst_retry1", retry_cnt1, 2'b00);
        modelReset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] hr;
        modelReset();
        @(posedge clk);
        #1;
        doReset();

        // Only B healthy: B may take prime only once the startup count saturates.
        repeatStimulus(2'b10, TO);
        checkOutput("startup_wait", prime, 2'b00);
        applyStimulus(2'b10, 1'b0, 1'b0);
        checkOutput("startup_b", prime, 2'b10);

        // Both healthy from release: A becomes prime one edge after fh settles.
        health = 2'b11;
        doReset();
        repeatStimulus(2'b11, STABLE);
        checkOutput("a_not_yet", prime, 2'b00);
        applyStimulus(2'b11, 1'b0, 1'b0);
        checkOutput("a_prime", prime, 2'b01);
        repeatStimulus(2'b11, 5);

        // First A failure: failover to B and an exact-length por pulse.
        repeatStimulus(2'b10, STABLE + 1);
        checkOutput("fail_prime", prime, 2'b10);
        checkOutput("fail_por", por, 2'b01);
        checkOutput("fail_retry", retry_cnt0, 2'b01);
        repeatStimulus(2'b10, PORC - 1);
        checkOutput("por_last", por, 2'b01);
        applyStimulus(2'b10, 1'b0, 1'b0);
        checkOutput("por_end", por, 2'b00);
        repeatStimulus(2'b11, 10);

        // Second failure pulses again, third locks A out without a pulse.
        repeatStimulus(2'b10, 30);
        repeatStimulus(2'b11, 10);
        repeatStimulus(2'b10, 30);
        checkOutput("lock_a", lockout, 2'b01);
        checkOutput("lock_por", por, 2'b00);
        checkOutput("lock_retry", retry_cnt0, 2'b10);
        repeatStimulus(2'b11, 10);
        applyStimulus(2'b11, 1'b0, 1'b1);
        checkOutput("clear_lock", lockout, 2'b00);
        checkOutput("clear_retry", retry_cnt0, 2'b00);

        // Manual swaps while both channels are eligible.
        applyStimulus(2'b11, 1'b1, 1'b0);
        checkOutput("swap_to_a", prime, 2'b01);
        applyStimulus(2'b11, 1'b1, 1'b0);
        checkOutput("swap_to_b", prime, 2'b10);
        applyStimulus(2'b11, 1'b1, 1'b0);
        repeatStimulus(2'b11, 3);

        // Lock B out, then a swap request must be ignored.
        for (int r = 0; r < 3; r++) begin
            repeatStimulus(2'b01, 30);
            repeatStimulus(2'b11, 10);
        end
        checkOutput("lock_b", lockout, 2'b10);
        applyStimulus(2'b11, 1'b1, 1'b0);
        checkOutput("swap_blocked", prime, 2'b01);

        // Two A failures, then a third coinciding with clear_lockout.
        for (int r = 0; r < 2; r++) begin
            repeatStimulus(2'b10, 30);
            repeatStimulus(2'b11, 10);
        end
        repeatStimulus(2'b10, STABLE);
        applyStimulus(2'b10, 1'b0, 1'b1);
        checkOutput("clr_fail_por", por, 2'b01);
        checkOutput("clr_fail_retry", retry_cnt0, 2'b01);
        checkOutput("clr_fail_lock", lockout, 2'b00);
        repeatStimulus(2'b11, 30);

        // Short glitch on both channels is filtered out entirely.
        repeatStimulus(2'b00, STABLE - 1);
        repeatStimulus(2'b11, 10);
        checkOutput("glitch_por", por, 2'b00);

        // Reset during a por pulse aborts it for good.
        repeatStimulus(2'b10, STABLE + 3);
        checkOutput("pre_rst_por", por, 2'b01);
        doReset();
        repeatStimulus(2'b11, 30);

        // Randomized traffic with slow health changes and occasional requests.
        hr = 2'b11;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) hr[0] = ~hr[0];
            if ($urandom_range(0, 15) == 0) hr[1] = ~hr[1];
            applyStimulus(hr, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
